// File: rtl/fft_mem_pkg.sv
// Shared types and helpers for the FFT sample-RAM read side.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fft_mem_pkg;

    // Depth of the output skid FIFO; the issue rule keeps at most this many beats in flight.
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Reverse the low w bits of v (w <= 32); bits above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r >> (32 - w);
    endfunction

endpackage

// File: rtl/fft_skid_fifo2.sv
// Two-entry FIFO that decouples RAM read data from the downstream handshake.
// Latency: a push is visible at dout the cycle after it is written; push and pop may share a cycle.
// Backpressure: none of its own; the caller only pushes when a slot is free (push when full is dropped).
module fft_skid_fifo2
    import fft_mem_pkg::*;
#(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   cnt
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_push;
    logic         do_pop;

    // Next-state for storage, pointers and occupancy; pop on empty is ignored.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_pop   = pop && (cnt_q != 2'd0);
        do_push  = push && ((cnt_q != 2'(FIFO_DEPTH)) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset clears storage so the head reads as zero.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = mem_q[rd_ptr_q];
    assign cnt  = cnt_q;

endmodule

// File: rtl/fft_reorder_reader.sv
// Reads one N-point frame from the sample RAM (bit-reversed order with FFT_REORDER_BITREV_EN, else natural) and streams it out.
// Latency: first o_valid 2 cycles after start; 1 beat/cycle while o_ready is held high.
// Backpressure: reads are only issued when the 2-entry FIFO can absorb them, so o_ready=0 stalls with no loss.
module fft_reorder_reader
    import fft_mem_pkg::*;
#(
    parameter int D_WIDTH = 10,
    parameter int A_WIDTH = 9
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    output logic [A_WIDTH-1:0] raddr,
    input  logic [D_WIDTH-1:0] rdata,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [D_WIDTH-1:0] o_data,
    output logic               o_last,
    output logic               busy,
    output logic               done
);

    typedef struct packed {
        logic               last;
        logic [D_WIDTH-1:0] data;
    } beat_t;

    localparam logic [A_WIDTH-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] cnt_q, cnt_d;
    logic               rd_pending_q, rd_pending_d;
    logic               last_pend_q, last_pend_d;
    logic [1:0]         fifo_cnt;
    logic [2:0]         occ;
    logic               pop;
    logic               issue;
    beat_t              push_beat;
    beat_t              head_beat;

    assign o_valid   = (fifo_cnt != 2'd0);
    assign pop       = o_valid && o_ready;
    assign push_beat = '{last: last_pend_q, data: rdata};

    // Issue a read only if the FIFO plus the read in flight, after this cycle's pop, leaves room for it.
    always_comb begin
        occ   = 3'(fifo_cnt) + 3'(rd_pending_q) - 3'(pop);
        issue = (state_q == READ) && (occ <= 3'd1);
    end

    // FSM next state plus counter / pending-read bookkeeping; start only matters in IDLE.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_pending_d = issue;
        last_pend_d  = issue && (cnt_q == CNT_MAX);
        if (issue) begin
            cnt_d = cnt_q + 1'b1;
        end
        case (state_q)
            IDLE:    if (start) state_d = READ;
            READ:    if (issue && (cnt_q == CNT_MAX)) state_d = DRAIN;
            DRAIN:   if (pop && o_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read address follows the counter, so it only moves when a read is issued.
    always_comb begin
`ifdef FFT_REORDER_BITREV_EN
        raddr = A_WIDTH'(bitrev(32'(cnt_q), A_WIDTH));
`else
        raddr = cnt_q;
`endif
    end

    // Control registers; a reset mid-frame abandons the frame and any read in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rd_pending_q <= 1'b0;
            last_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_pending_q <= rd_pending_d;
            last_pend_q  <= last_pend_d;
        end
    end

    fft_skid_fifo2 #(
        .W (D_WIDTH + 1)
    ) u_fifo (
        .clk  (clk),
        .rstn (rstn),
        .push (rd_pending_q),
        .din  (push_beat),
        .pop  (pop),
        .dout (head_beat),
        .cnt  (fifo_cnt)
    );

    assign o_data = head_beat.data;
    assign o_last = o_valid && head_beat.last;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_fft_reorder_reader.sv
// Directed bench for fft_reorder_reader: N=8 instance for ordering/timing/backpressure/reset, default-size instance for a full frame.
// Latency: checks first o_valid 2 cycles after start and done 1 cycle after the last beat.
// Backpressure: drives o_ready high, random, and held low to exercise stalls.
module tb_fft_reorder_reader;

    logic       clk;
    logic       rstn;
    logic       start;
    logic [2:0] raddr;
    logic [9:0] rdata;
    logic       o_valid;
    logic       o_ready;
    logic [9:0] o_data;
    logic       o_last;
    logic       busy;
    logic       done;

    logic       b_start;
    logic [8:0] b_raddr;
    logic [9:0] b_rdata;
    logic       b_valid;
    logic       b_ready;
    logic [9:0] b_data;
    logic       b_last;
    logic       b_busy;
    logic       b_done;

    int total;
    int bad;
    int exp8 [8];

    fft_reorder_reader #(.D_WIDTH(10), .A_WIDTH(3)) dut (
        .clk(clk), .rstn(rstn), .start(start), .raddr(raddr), .rdata(rdata),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last),
        .busy(busy), .done(done)
    );

    fft_reorder_reader #(.D_WIDTH(10), .A_WIDTH(9)) dut_big (
        .clk(clk), .rstn(rstn), .start(b_start), .raddr(b_raddr), .rdata(b_rdata),
        .o_valid(b_valid), .o_ready(b_ready), .o_data(b_data), .o_last(b_last),
        .busy(b_busy), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models preloaded with ram[a] = a, one-cycle registered read.
    always @(posedge clk) begin
        rdata   <= 10'(raddr);
        b_rdata <= 10'(b_raddr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_big(input int i);
        int r;
        r = 0;
`ifdef FFT_REORDER_BITREV_EN
        for (int b = 0; b < 9; b++) begin
            if (i[b]) r = r | (1 << (8 - b));
        end
`else
        r = i;
`endif
        return r;
    endfunction

    // mode 0: ready high; 1: random ready; 2: ready low for 10 cycles; 3: ready high with stray start pulses.
    // Entered at #1 in an IDLE cycle; leaves at #1 in the IDLE cycle right after done.
    task automatic run_frame(input int mode, input string nm);
        int k, beat, first_k, last_k, done_k, stab_err, occ_err;
        logic       was_stall;
        logic [9:0] held;
        logic       held_last;
        beat = 0; first_k = -1; last_k = -1; done_k = -1;
        stab_err = 0; occ_err = 0; was_stall = 1'b0; held = '0; held_last = 1'b0;
        o_ready = 1'b1;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (done_k < 0 && k < 200) begin
            case (mode)
                1:       o_ready = 1'($urandom_range(0, 1));
                2:       o_ready = (k >= 10);
                default: o_ready = 1'b1;
            endcase
            start = (mode == 3) && (k == 3 || k == 6);
            if (mode == 2 && k == 9) begin
                chk({nm, "_hold_raddr"}, 32'(raddr), 32'(exp8[2]));
                chk({nm, "_hold_fifo"}, 32'(dut.fifo_cnt), 32'd2);
            end
            if (dut.fifo_cnt > 2'd2) occ_err++;
            if (was_stall && (!o_valid || o_data !== held || o_last !== held_last)) stab_err++;
            if (o_valid && first_k < 0) first_k = k;
            if (done) done_k = k;
            if (o_valid && o_ready) begin
                if (beat < 8) begin
                    chk($sformatf("%s_data%0d", nm, beat), 32'(o_data), 32'(exp8[beat]));
                    chk($sformatf("%s_last%0d", nm, beat), 32'(o_last), 32'(beat == 7));
                end
                if (o_last) last_k = k;
                beat++;
            end
            was_stall = o_valid && !o_ready;
            held      = o_data;
            held_last = o_last;
            if (done_k < 0) begin
                @(posedge clk); #1;
                k++;
            end
        end
        start = 1'b0;
        chk({nm, "_beats"}, 32'(beat), 32'd8);
        chk({nm, "_first_valid"}, 32'(first_k), 32'd2);
        chk({nm, "_done_after_last"}, 32'(done_k), 32'(last_k + 1));
        chk({nm, "_stable"}, 32'(stab_err), 32'd0);
        chk({nm, "_fifo_max"}, 32'(occ_err), 32'd0);
        @(posedge clk); #1;
        chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int beat, k, bb, berr, blast;
        total = 0;
        bad   = 0;
`ifdef FFT_REORDER_BITREV_EN
        exp8 = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
        exp8 = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
        rstn = 1'b0; start = 1'b0; o_ready = 1'b0; b_start = 1'b0; b_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_busy",  32'(busy),    32'd0);
        chk("rst_done",  32'(done),    32'd0);
        chk("rst_raddr", 32'(raddr),   32'd0);
        chk("rst_data",  32'(o_data),  32'd0);
        chk("rst_last",  32'(o_last),  32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Back-to-back frames: each start lands in the cycle after the previous done.
        run_frame(0, "plain");
        run_frame(1, "rand");
        run_frame(2, "stall");
        run_frame(3, "restart");

        // Reset one cycle after the 3rd beat is accepted.
        o_ready = 1'b1;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        beat = 0;
        k = 0;
        while (beat < 3 && k < 50) begin
            if (o_valid && o_ready) beat++;
            @(posedge clk); #1;
            k++;
        end
        chk("rst_mid_beats", 32'(beat), 32'd3);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        chk("rst_mid_valid", 32'(o_valid), 32'd0);
        chk("rst_mid_busy",  32'(busy),    32'd0);
        chk("rst_mid_raddr", 32'(raddr),   32'd0);
        run_frame(0, "after_rst");

        // Default-size frame: 512 beats in the expected order, o_last on the final one.
        b_ready = 1'b1;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        bb = 0; berr = 0; blast = -1; k = 0;
        while (!b_done && k < 700) begin
            if (b_valid && b_ready) begin
                if (b_data !== 10'(exp_big(bb))) berr++;
                if (b_last) blast = bb;
                bb++;
            end
            @(posedge clk); #1;
            k++;
        end
        chk("big_beats", 32'(bb),    32'd512);
        chk("big_data",  32'(berr),  32'd0);
        chk("big_last",  32'(blast), 32'd511);
        chk("big_done",  32'(b_done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
